alu_port_arbiter: RTL
=====================

# alu_port_arbiter

Two-requester arbiter that shares the single combinational `alu` between the core execute path (port 0) and an auxiliary requester such as a lookup/parity helper engine (port 1). Each port issues operations over a valid/ready request channel. Each port receives a registered result and branch flag over a valid/ready response channel. The block sits between the requesters and the `alu` instance: it drives `alu_cmd`/`inA`/`inB` and captures `rslt`/`doBranch`.

## Interface
- `DW`, 8 — data width of operands and result.
- `CW`, 5 — ALU command width.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `pN_req_valid`  in  1  — port N (N=0,1) request present.
- `pN_req_ready`  out  1  — port N request accepted this cycle (grant).
- `pN_cmd`  in  CW  — ALU command for port N.
- `pN_a`, `pN_b`  in  DW each  — operands for port N.
- `pN_resp_valid`  out  1  — port N response held in register.
- `pN_resp_ready`  in  1  — port N consumes response.
- `pN_rslt`  out  DW  — captured ALU result.
- `pN_branch`  out  1  — captured `doBranch`.
- `alu_cmd`  out  CW  — to `alu.alu_cmd`.
- `alu_inA`, `alu_inB`  out  DW each  — to `alu.inA`/`inB`.
- `alu_rslt`  in  DW  — from `alu.rslt`.
- `alu_doBranch`  in  1  — from `alu.doBranch`.

## Operation
- **Eligibility.** Port N is eligible when `pN_req_valid && (!pN_resp_valid || pN_resp_ready)`. There is at most one outstanding response per port. A response draining in a cycle frees its slot in that same cycle.
- **Arbitration.** Round-robin, using the 1-bit register `last_grant`, which resets to 1.
  - Both ports eligible: grant the port that is not `last_grant`.
  - One port eligible: grant it.
  - No port eligible: no grant.
- **Grant outputs.** `pN_req_ready` is combinational and equals the grant for port N. At most one ready is high per cycle. Both readies are forced to 0 while `reset` is high.
- **ALU drive (combinational).**
  - With a grant: `alu_cmd`/`alu_inA`/`alu_inB` equal the granted port's `cmd`/`a`/`b`.
  - Otherwise: `alu_cmd` = 5'b00000 (NOP), operands 0.
- **Capture.** On a granted edge:
  - `pN_rslt` <= `alu_rslt`, `pN_branch` <= `alu_doBranch`, `pN_resp_valid` <= 1.
  - `last_grant` <= N.
- **Response drain.** On `pN_resp_valid && pN_resp_ready` with no new grant to port N, `pN_resp_valid` <= 0.
  - Drain and new grant on the same edge: the new capture overwrites and `pN_resp_valid` stays 1.
- **Response stability.** `pN_rslt`/`pN_branch` hold while `pN_resp_valid && !pN_resp_ready`.
- **Requester obligations.** Hold `cmd`/`a`/`b` stable and `req_valid` high until `req_ready` is seen. The arbiter does not buffer requests.
- **Command decoding.** Commands are passed through opaquely; the arbiter does not decode them. Branch commands (BEQ 00011, B 00010, B_LOOKUP 00001) return `rslt`=0 with `branch` per the ALU. All other commands return `branch`=0.
- **Counters.** 8-bit `pN_grant_cnt` registers count accepted requests per port, wrap at 255->0, and reset to 0. They are debug outputs, one per port: `pN_grant_cnt  out  8`.

## Timing
- **Reset values.** All `resp_valid`=0, `rslt`=0, `branch`=0, `grant_cnt`=0, `last_grant`=1. `req_ready`=0 while `reset`=1. ALU outputs are NOP/0.
- **Latency.** Request accepted at edge t; response valid from t+1 onward.
- **Throughput.**
  - One operation per cycle in aggregate.
  - A single uncontended port with `resp_ready` held high sustains 1 op/cycle.
  - Under continuous contention, each port gets 1 op every 2 cycles, strictly alternating.
- **Reset mid-operation.**
  - Pending responses are discarded: `resp_valid`=0 on the edge after `reset` is sampled high.
  - An in-flight request presented during reset is not accepted and must be re-presented.
- **Pointer update.** `last_grant` updates only on an actual grant. Idle cycles do not move the pointer.
- **Combinational paths.** There is no combinational path from `alu_rslt`/`alu_doBranch` to any output. Request-to-ALU paths and `resp_ready`-to-`req_ready` paths are combinational.

## Test plan
- **Single op.** After reset, p0 ADD (01000) a=3, b=4 with `p0_resp_ready`=1.
  - `p0_req_ready`=1 in the same cycle; next cycle `p0_resp_valid`=1, `p0_rslt`=7, `p0_branch`=0.
  - `p0_grant_cnt`=1.
- **Contention.** Both ports valid in the first cycle after reset: p0 SUB (01001) 9,2 and p1 OR (01011) 0x0F,0xF0.
  - p0 is granted first, p1 on the next cycle.
  - Responses: `p0_rslt`=7 at t+1, `p1_rslt`=0xFF at t+2.
  - Continuous requests alternate 0,1,0,1.
- **Backpressure.** `p0_resp_ready`=0 with p0 issuing two ADDs (1+1, then 2+2).
  - The second request stalls (`p0_req_ready`=0) and `p0_rslt` holds 2.
  - A p1 request is granted during the stall.
  - Raising `p0_resp_ready` grants the second ADD in the same cycle; next cycle `p0_rslt`=4.
- **Branch capture.**
  - p1 BEQ (00011) a=5, b=5 → `p1_branch`=1, `p1_rslt`=0.
  - p1 BEQ a=5, b=6 → `p1_branch`=0.
- **Reset mid-op.** With `p0_resp_valid`=1 pending (`resp_ready`=0), pulse `reset` for 1 cycle.
  - Next cycle: `p0_resp_valid`=0, counters=0.
  - Next contention grants p0 first.
- **Idle / wrap.**
  - No requests → `alu_cmd`=00000 and `alu_inA`=`alu_inB`=0.
  - 256 p1 grants → `p1_grant_cnt` returns to 0.

Source files
------------

// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each port has a single registered response slot that holds until the port consumes it.
module alu_port_arbiter #(
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic [CW-1:0] p0_cmd,
    input  logic [DW-1:0] p0_a,
    input  logic [DW-1:0] p0_b,
    output logic          p0_resp_valid,
    input  logic          p0_resp_ready,
    output logic [DW-1:0] p0_rslt,
    output logic          p0_branch,
    output logic [7:0]    p0_grant_cnt,

    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic [CW-1:0] p1_cmd,
    input  logic [DW-1:0] p1_a,
    input  logic [DW-1:0] p1_b,
    output logic          p1_resp_valid,
    input  logic          p1_resp_ready,
    output logic [DW-1:0] p1_rslt,
    output logic          p1_branch,
    output logic [7:0]    p1_grant_cnt,

    output logic [CW-1:0] alu_cmd,
    output logic [DW-1:0] alu_inA,
    output logic [DW-1:0] alu_inB,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_doBranch
);

    logic last_grant;
    logic elig0, elig1;
    logic gnt0, gnt1;

    // A slot being drained this cycle can be refilled on the same edge.
    assign elig0 = p0_req_valid && (!p0_resp_valid || p0_resp_ready);
    assign elig1 = p1_req_valid && (!p1_resp_valid || p1_resp_ready);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    always_comb begin
        alu_cmd = '0;
        alu_inA = '0;
        alu_inB = '0;
        if (gnt0) begin
            alu_cmd = p0_cmd;
            alu_inA = p0_a;
            alu_inB = p0_b;
        end else if (gnt1) begin
            alu_cmd = p1_cmd;
            alu_inA = p1_a;
            alu_inB = p1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= 1'b1;
            p0_resp_valid <= 1'b0;
            p0_rslt       <= '0;
            p0_branch     <= 1'b0;
            p0_grant_cnt  <= '0;
            p1_resp_valid <= 1'b0;
            p1_rslt       <= '0;
            p1_branch     <= 1'b0;
            p1_grant_cnt  <= '0;
        end else begin
            if (gnt0) begin
                p0_rslt       <= alu_rslt;
                p0_branch     <= alu_doBranch;
                p0_resp_valid <= 1'b1;
                p0_grant_cnt  <= p0_grant_cnt + 8'd1;
                last_grant    <= 1'b0;
            end else if (p0_resp_valid && p0_resp_ready) begin
                p0_resp_valid <= 1'b0;
            end

            if (gnt1) begin
                p1_rslt       <= alu_rslt;
                p1_branch     <= alu_doBranch;
                p1_resp_valid <= 1'b1;
                p1_grant_cnt  <= p1_grant_cnt + 8'd1;
                last_grant    <= 1'b1;
            end else if (p1_resp_valid && p1_resp_ready) begin
                p1_resp_valid <= 1'b0;
            end
        end
    end

endmodule
